sub_byte_engine: RTL
====================

SUB_BYTE_ENGINE -- requirements
Module: sub_byte_engine

Interface
REQ-001 The block SHALL have parameter LANES, default 4: bytes substituted per clock; legal values 1, 2, 4, 8, 16.
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset; all ports are listed below.
REQ-003 clock  input  1  single clock; all state changes on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 startTransition  input  1  request; sampled only in IDLE.
REQ-006 mode  input  1  0 = forward S-box (SubBytes), 1 = inverse S-box (InvSubBytes); sampled with startTransition.
REQ-007 inputData  input  128  AES state; byte 0 = bits [127:120], byte 15 = bits [7:0].
REQ-008 outputData  output  128  substituted state; registered, held until the next completion.
REQ-009 busy  output  1  high in RUN and DONE.
REQ-010 done  output  1  one-cycle pulse; outputData is valid and updated in this cycle.

Function
REQ-011 The block SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-012 In IDLE with startTransition=1 at a rising edge, the block SHALL latch inputData and mode into internal registers, clear the lane counter and enter RUN.
REQ-013 In RUN, each cycle SHALL substitute bytes [cnt*LANES .. cnt*LANES+LANES-1] of the working register in place and increment cnt.
REQ-014 After N = 16/LANES RUN cycles (cnt = N-1 processed), the FSM SHALL enter DONE.
REQ-015 On entry to DONE, outputData SHALL be loaded from the working register, and done SHALL be high for exactly that one cycle; the FSM then returns to IDLE.
REQ-016 Latency SHALL be N+1 rising edges from the edge sampling startTransition to the cycle in which done is high.
REQ-017 startTransition SHALL be ignored while busy=1; no queuing occurs.
REQ-018 If startTransition is held high continuously, a new operation SHALL start on the first IDLE cycle after each DONE, giving a throughput of one block per N+2 cycles.
REQ-019 inputData and mode changes after the sampling edge SHALL NOT affect the operation in progress.
REQ-020 cnt width SHALL be max(1, log2(N)); for LANES=16 there is one RUN cycle.
REQ-021 The S-box tables SHALL be constant combinational lookups replicated LANES times, and SHALL contain no RAM.
REQ-022 An illegal LANES value SHALL cause a simulation-time $display error followed by $finish.

Reset
REQ-023 While reset=1, the FSM SHALL be in IDLE, and cnt, the working register, outputData, busy and done SHALL all be 0.
REQ-024 Reset asserted mid-operation SHALL abort the operation immediately; no done pulse occurs, and outputData reads 0.
REQ-025 After reset deasserts, the first startTransition sampled in IDLE SHALL begin a fresh operation.

Configuration
REQ-026 The macro SUB_BYTE_DUAL_MODE_EN controls whether the forward table is built:
- Defined: both forward and inverse tables are built, and mode selects between them per REQ-006.
- Undefined: only the inverse table is built; mode is ignored and every operation is InvSubBytes, saving LANES x 256-byte table area.

Verification
REQ-027 The bench SHALL cover the following scenarios, with LANES=4 unless stated:
- Inverse vector: mode=1, inputData=1a3174470b1b226e59084e3c540e1f00 -> done 5 cycles after start; outputData=432eca169e44944515bfb66dfdd7cb52.
- Forward vector (macro defined): mode=0, inputData=432eca169e44944515bfb66dfdd7cb52 -> outputData=1a3174470b1b226e59084e3c540e1f00. With the macro undefined, mode=0, inputData=00..00 -> outputData=52525252525252525252525252525252.
- Lane sweep: LANES in {1, 2, 8, 16}, inverse of inputData=63636363636363636363636363636363 -> outputData=0, with done after 17, 9, 3 and 2 edges respectively.
- Busy rejection: start, then change inputData and pulse startTransition while busy -> first result unchanged; only one done pulse.
- Mid-operation reset: assert reset during RUN cycle 2 -> busy=0, done never pulses, outputData=0; a new start afterwards completes normally.

Source files
------------

// File: rtl/sub_byte_engine.sv
// AES SubBytes / InvSubBytes engine, LANES bytes substituted per clock.
// Define SUB_BYTE_DUAL_MODE_EN to build the forward table; otherwise every operation is InvSubBytes.
module sub_byte_engine #(
    parameter int LANES = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         startTransition,
    input  logic         mode,
    input  logic [127:0] inputData,
    output logic [127:0] outputData,
    output logic         busy,
    output logic         done
);

    localparam bit LEGAL = (LANES == 1) || (LANES == 2) || (LANES == 4) ||
                           (LANES == 8) || (LANES == 16);
    localparam int N  = LEGAL ? 16 / LANES : 1;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    generate
        if (!LEGAL) begin : g_bad_lanes
            initial begin
                $display("ERROR: sub_byte_engine LANES=%0d is not 1, 2, 4, 8 or 16", LANES);
                $finish;
            end
        end
    endgenerate

    // Byte 0 of each table sits in the top bits so index i lives at [(255-i)*8 +: 8].
    localparam logic [2047:0] INV_TBL = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        return INV_TBL[{~x, 3'b000} +: 8];
    endfunction

`ifdef SUB_BYTE_DUAL_MODE_EN
    localparam logic [2047:0] FWD_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] fwd_sbox(input logic [7:0] x);
        return FWD_TBL[{~x, 3'b000} +: 8];
    endfunction
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    logic [CW-1:0]  cnt;
    logic [127:0]   work;
    logic [127:0]   next_work;
    logic           mode_r;
    logic [3:0]     base;
    logic [3:0]     pos      [LANES];
    logic [7:0]     lane_in  [LANES];
    logic [7:0]     lane_out [LANES];

    assign base = 4'(int'(cnt) * LANES);

    generate
        for (genvar l = 0; l < LANES; l++) begin : g_lane
            assign pos[l]     = base + 4'(l);
            assign lane_in[l] = work[{~pos[l], 3'b000} +: 8];
`ifdef SUB_BYTE_DUAL_MODE_EN
            assign lane_out[l] = mode_r ? inv_sbox(lane_in[l])
                                        : fwd_sbox(lane_in[l]);
`else
            assign lane_out[l] = inv_sbox(lane_in[l]);
`endif
        end
    endgenerate

`ifndef SUB_BYTE_DUAL_MODE_EN
    logic unused_mode;
    assign unused_mode = mode_r;
`endif

    always_comb begin
        next_work = work;
        for (int l = 0; l < LANES; l++) begin
            next_work[{~pos[l], 3'b000} +: 8] = lane_out[l];
        end
    end

    // The last RUN edge both finishes the substitution and publishes it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            work       <= '0;
            mode_r     <= 1'b0;
            outputData <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (startTransition) begin
                        work   <= inputData;
                        mode_r <= mode;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    work <= next_work;
                    cnt  <= cnt + 1'b1;
                    if (cnt == CW'(N - 1)) begin
                        outputData <= next_work;
                        done       <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
